// File: rtl/ps2_vram_bridge.sv
// Bus bridge: buffered PS/2 scancode FIFO with status register, and range-checked character VRAM writes.
// Optional registered keyboard interrupt enabled by defining PS2_VRAM_BRIDGE_IRQ_EN.
module ps2_vram_bridge #(
  parameter int         FIFO_DEPTH  = 16,
  parameter int         VRAM_AW     = 13,
  parameter int         VRAM_DEPTH  = 4800,
  parameter logic [3:0] BASE_NIBBLE = 4'hD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr_bus,
  input  logic [31:0]        cpu_data2bus,
  input  logic               mem_w,
  input  logic               mem_r,
  output logic [31:0]        cpu_data4bus,
  input  logic               ps2_ready,
  input  logic [7:0]         ps2_data,
  output logic [VRAM_AW-1:0] addr_2_charvram,
  output logic [7:0]         data_2_charvram,
  output logic               wea_2_charvram,
  output logic               irq
);

  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam logic [31:0] DEPTH_L = 32'(VRAM_DEPTH);

  logic [7:0]         fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]      head_r;
  logic [PW-1:0]      tail_r;
  logic [CW-1:0]      count_r;
  logic               overflow_r;
  logic               ps2_prev_r;

  logic               sel_s;
  logic               empty_s;
  logic               full_s;
  logic               push_s;
  logic               pop_s;
  logic               push_ok_s;
  logic               vram_wr_s;
  logic               ovf_clr_s;
  logic [VRAM_AW-1:0] vram_a_s;
  logic [7:0]         vram_d_s;
  logic [7:0]         count8_s;
  logic               unused_s;

  assign sel_s     = (addr_bus[31:28] == BASE_NIBBLE);
  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == CW'(FIFO_DEPTH));
  assign push_s    = ps2_ready & ~ps2_prev_r;
  // A simultaneous write owns the cycle, so a read strobe alongside it never pops.
  assign pop_s     = sel_s & mem_r & ~mem_w & ~addr_bus[2] & ~empty_s;
  assign push_ok_s = push_s & (~full_s | pop_s);
  assign vram_a_s  = cpu_data2bus[VRAM_AW+7:8];
  assign vram_d_s  = cpu_data2bus[7:0];
  assign vram_wr_s = sel_s & mem_w & ~addr_bus[2] & (32'(vram_a_s) < DEPTH_L);
  assign ovf_clr_s = sel_s & mem_w & addr_bus[2] & cpu_data2bus[2];
  assign count8_s  = 8'(count_r);
  assign unused_s  = ^{addr_bus[27:3], addr_bus[1:0], cpu_data2bus[31:VRAM_AW+8]};

  // Read data mux: head byte or status word, zero when idle or FIFO empty.
  always_comb begin
    cpu_data4bus = 32'h0000_0000;
    if (sel_s && mem_r) begin
      if (addr_bus[2]) begin
        cpu_data4bus = {16'h0000, count8_s, 5'b00000, overflow_r, full_s, empty_s};
      end else if (!empty_s) begin
        cpu_data4bus = {24'h00_0000, fifo_mem_r[head_r]};
      end else begin
        cpu_data4bus = 32'h0000_0000;
      end
    end else begin
      cpu_data4bus = 32'h0000_0000;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_r[tail_r] <= ps2_data;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and ps2_ready edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
      ps2_prev_r <= 1'b0;
    end else begin
      ps2_prev_r <= ps2_ready;
      if (push_ok_s) begin
        tail_r <= tail_r + PW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end
      count_r <= count_r + CW'(push_ok_s) - CW'(pop_s);
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // VRAM write port: one-cycle enable pulse, address/data hold their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_2_charvram <= {VRAM_AW{1'b0}};
      data_2_charvram <= 8'h00;
      wea_2_charvram  <= 1'b0;
    end else begin
      wea_2_charvram <= vram_wr_s;
      if (vram_wr_s) begin
        addr_2_charvram <= vram_a_s;
        data_2_charvram <= vram_d_s;
      end
    end
  end

`ifdef PS2_VRAM_BRIDGE_IRQ_EN
  // Interrupt follows pending data or an unacknowledged overflow, one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= ~empty_s | overflow_r;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_vram_bridge.sv
// Directed scoreboard bench for ps2_vram_bridge: FIFO, status, VRAM writes, overflow, reset, irq.
module tb_ps2_vram_bridge;

  localparam logic [31:0] A_DATA = 32'hD000_0000;
  localparam logic [31:0] A_STAT = 32'hD000_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_bus;
  logic [31:0] cpu_data2bus;
  logic        mem_w;
  logic        mem_r;
  logic [31:0] cpu_data4bus;
  logic        ps2_ready;
  logic [7:0]  ps2_data;
  logic [12:0] addr_2_charvram;
  logic [7:0]  data_2_charvram;
  logic        wea_2_charvram;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_q[$];
  logic [31:0] exp_q[$];
  logic        m_ovf   = 1'b0;
  logic [12:0] m_vaddr = 13'h0000;
  logic [7:0]  m_vdata = 8'h00;

  ps2_vram_bridge dut (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .cpu_data2bus(cpu_data2bus),
    .mem_w(mem_w), .mem_r(mem_r), .cpu_data4bus(cpu_data4bus),
    .ps2_ready(ps2_ready), .ps2_data(ps2_data),
    .addr_2_charvram(addr_2_charvram), .data_2_charvram(data_2_charvram),
    .wea_2_charvram(wea_2_charvram), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_word();
    logic [7:0] c;
    c = 8'(model_q.size());
    return {16'h0000, c, 5'b00000, m_ovf, (model_q.size() == 16), (model_q.size() == 0)};
  endfunction

  function automatic logic exp_irq();
`ifdef PS2_VRAM_BRIDGE_IRQ_EN
    return (model_q.size() != 0) | m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_push(input logic [7:0] b);
    if (model_q.size() < 16) model_q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic ps2_push(input logic [7:0] b, input int hold);
    ps2_data  = b;
    ps2_ready = 1'b1;
    model_push(b);
    repeat (hold) tick();
    ps2_ready = 1'b0;
    tick();
  endtask

  task automatic read_data(input string tag);
    addr_bus = A_DATA;
    mem_r    = 1'b1;
    exp_q.push_back((model_q.size() == 0) ? 32'h0 : {24'h0, model_q.pop_front()});
    #2;
    chk(tag, cpu_data4bus, exp_q.pop_front());
    tick();
    mem_r = 1'b0;
  endtask

  task automatic read_status(input string tag);
    addr_bus = A_STAT;
    mem_r    = 1'b1;
    exp_q.push_back(status_word());
    #2;
    chk(tag, cpu_data4bus, exp_q.pop_front());
    tick();
    mem_r = 1'b0;
  endtask

  task automatic write_vram(input string tag, input logic [12:0] a, input logic [7:0] d);
    logic hit;
    hit          = (a < 13'd4800);
    addr_bus     = A_DATA;
    cpu_data2bus = {11'h000, a, d};
    mem_w        = 1'b1;
    if (hit) begin
      m_vaddr = a;
      m_vdata = d;
    end
    tick();
    mem_w = 1'b0;
    chk({tag, "_wea"}, {31'h0, wea_2_charvram}, {31'h0, hit});
    chk({tag, "_addr"}, {19'h0, addr_2_charvram}, {19'h0, m_vaddr});
    chk({tag, "_data"}, {24'h0, data_2_charvram}, {24'h0, m_vdata});
    tick();
    chk({tag, "_wea_end"}, {31'h0, wea_2_charvram}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; addr_bus = 32'h0; cpu_data2bus = 32'h0;
    mem_w = 1'b0; mem_r = 1'b0; ps2_ready = 1'b0; ps2_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;

    chk("reset_wea", {31'h0, wea_2_charvram}, 32'h0);
    chk("reset_addr", {19'h0, addr_2_charvram}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    read_status("reset_status");

    // Basic FIFO ordering; a held level pushes once
    ps2_push(8'h1C, 1);
    ps2_push(8'h32, 1);
    ps2_push(8'h21, 5);
    read_status("status_cnt3");
    read_data("rd_1c");
    read_data("rd_32");
    read_data("rd_21");
    read_data("rd_empty");
    read_status("status_empty");

    // VRAM writes in range and at the range boundary
    write_vram("vram_050", 13'h0050, 8'h41);
    write_vram("vram_4800", 13'd4800, 8'h77);
    write_vram("vram_4799", 13'd4799, 8'h5A);
    read_status("status_after_vram");

    // Overflow: 17 pushes, 17th dropped
    for (int i = 1; i <= 17; i++) ps2_push(8'(i), 1);
    read_status("status_full_ovf");
    tick();
    chk("irq_ovf", {31'h0, irq}, {31'h0, exp_irq()});
    addr_bus = A_STAT; cpu_data2bus = 32'h0000_0004; mem_w = 1'b1;
    m_ovf = 1'b0;
    tick();
    mem_w = 1'b0;
    read_status("status_ovf_clr");
    for (int i = 1; i <= 16; i++) read_data($sformatf("drain_%0d", i));
    read_status("status_drained");
    read_data("rd_after_drain");

    // Push coinciding with pop on a one-entry FIFO
    ps2_push(8'hA5, 1);
    addr_bus = A_DATA; mem_r = 1'b1; ps2_data = 8'h5B; ps2_ready = 1'b1;
    exp_q.push_back({24'h0, model_q.pop_front()});
    model_q.push_back(8'h5B);
    #2;
    chk("rd_pushpop_old", cpu_data4bus, exp_q.pop_front());
    tick();
    mem_r = 1'b0; ps2_ready = 1'b0;
    tick();
    read_status("status_pushpop");
    read_data("rd_pushpop_new");

    // Read and write together: write wins, no pop
    ps2_push(8'h66, 1);
    addr_bus = A_DATA; cpu_data2bus = {11'h000, 13'h0123, 8'hC3}; mem_w = 1'b1; mem_r = 1'b1;
    m_vaddr = 13'h0123; m_vdata = 8'hC3;
    tick();
    mem_w = 1'b0; mem_r = 1'b0;
    chk("rw_wea", {31'h0, wea_2_charvram}, 32'h1);
    chk("rw_addr", {19'h0, addr_2_charvram}, {19'h0, m_vaddr});
    read_status("status_rw_nopop");

    // irq follows occupancy; drains one cycle after the last pop
    tick();
    chk("irq_pending", {31'h0, irq}, {31'h0, exp_irq()});
    read_data("rd_66");
    tick();
    chk("irq_drained", {31'h0, irq}, {31'h0, exp_irq()});

    // Reset mid-operation with data queued and a VRAM pulse pending
    ps2_push(8'h11, 1);
    ps2_push(8'h22, 1);
    addr_bus = A_DATA; cpu_data2bus = {11'h000, 13'h0010, 8'h99}; mem_w = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; mem_w = 1'b0;
    model_q.delete(); m_ovf = 1'b0; m_vaddr = 13'h0000; m_vdata = 8'h00;
    chk("rst_wea", {31'h0, wea_2_charvram}, 32'h0);
    chk("rst_addr", {19'h0, addr_2_charvram}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    read_status("status_after_rst");
    read_data("rd_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_vram_bridge.md
Name: ps2_vram_bridge

Overview:
Memory-mapped peripheral bridge between the CPU bus, the PS/2 keyboard receiver and the character VRAM. It adds a buffered scancode FIFO so keystrokes are not lost between CPU polls, and a status register. Character VRAM writes are registered, with range checking. It sits on the system bus, decoded by the top address nibble, alongside the other peripheral bridges.

Parameters:
FIFO_DEPTH, 16, scancode FIFO entries; power of two, 2..256
VRAM_AW, 13, character VRAM address width
VRAM_DEPTH, 4800, number of valid VRAM cells; writes to addresses >= VRAM_DEPTH are dropped
BASE_NIBBLE, 4'hD, value of addr_bus[31:28] that selects this block

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
addr_bus  in  32  CPU address
cpu_data2bus  in  32  CPU write data
mem_w  in  1  CPU write strobe, one cycle per access
mem_r  in  1  CPU read strobe, one cycle per access
cpu_data4bus  out  32  read data to CPU
ps2_ready  in  1  PS/2 receiver byte-valid level
ps2_data  in  8  PS/2 received byte
addr_2_charvram  out  VRAM_AW  VRAM write address
data_2_charvram  out  8  VRAM write data
wea_2_charvram  out  1  VRAM write enable
irq  out  1  keyboard interrupt request

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: FIFO empty, count 0, overflow flag 0, ps2_ready edge register 0, addr_2_charvram 0, data_2_charvram 0, wea_2_charvram 0, irq 0.
- Select: sel = (addr_bus[31:28] == BASE_NIBBLE). The register is chosen by addr_bus[2]: 0 = DATA, 1 = STATUS.
- Push:
  - A push occurs on the rising edge of ps2_ready: ps2_ready=1 while the registered previous value is 0.
  - A level held high pushes exactly once.
  - ps2_data is written at the tail.
- Read DATA (sel & mem_r & addr_bus[2]=0):
  - cpu_data4bus = {24'h0, head byte}, combinational.
  - The FIFO pops at the clock edge ending that cycle.
  - If empty: returns 32'h0 and state is unchanged.
- Read STATUS: cpu_data4bus = {16'h0, count[7:0], 5'b0, overflow, full, empty}. No side effects.
- cpu_data4bus = 0 whenever the block is not selected or not reading.
- Write DATA (sel & mem_w & addr_bus[2]=0):
  - a = cpu_data2bus[VRAM_AW+7:8], d = cpu_data2bus[7:0].
  - If a < VRAM_DEPTH: the next cycle drives addr_2_charvram=a, data_2_charvram=d, wea_2_charvram=1.
  - Latency is exactly 1 cycle. wea is a single-cycle pulse.
  - addr and data hold their last value afterwards.
  - If a >= VRAM_DEPTH: no pulse and outputs are unchanged.
- Write STATUS: writing 1 to cpu_data2bus[2] clears overflow. Other bits are ignored.
- mem_r and mem_w both high: the write takes priority and no pop occurs.
- Simultaneous push and pop:
  - Not empty: both happen, count is unchanged, and pointers advance with wrap modulo FIFO_DEPTH.
  - Empty: the push happens; the pop is ignored and returns 0.
- Push when full without a pop: the byte is dropped, overflow is set to 1 (sticky), and FIFO contents are unchanged. Push when full with a pop: accepted.
- count range is 0..FIFO_DEPTH. full = (count == FIFO_DEPTH); empty = (count == 0).
- Reset mid-operation: all state clears on the next edge. A pending VRAM pulse is cancelled (wea=0 after the reset edge).

Optional Feature:
- Macro: PS2_VRAM_BRIDGE_IRQ_EN.
- Defined: irq is registered, irq = !empty | overflow, updated every cycle. It deasserts one cycle after the FIFO drains and overflow is cleared.
- Undefined: irq is tied to 0, and no irq logic is synthesised.

Test Plan:
- Reset, then read STATUS at addr 32'hD000_0004 -> cpu_data4bus=32'h0000_0001 (empty); wea_2_charvram=0.
- Pulse ps2_ready with data 8'h1C, 8'h32, 8'h21; hold the last pulse high 5 cycles -> STATUS count=3; three DATA reads at 32'hD000_0000 return 32'h1C, 32'h32, 32'h21; a fourth read returns 0 with count 0.
- Write 32'h0012_3441 to 32'hD000_0000 -> one cycle later addr=13'h1234?; use a=13'h0050, i.e. write 32'h0000_5041 -> addr_2_charvram=13'h050, data=8'h41, wea high exactly 1 cycle. Then write with a=13'd4800 -> no wea pulse.
- Push 17 bytes with no reads (FIFO_DEPTH=16) -> full=1, overflow=1, 17th byte dropped. Write 32'h4 to STATUS -> overflow=0; DATA reads return bytes 1..16 in order.
- FIFO holds 1 byte; ps2_ready rises in the same cycle as a DATA read -> read returns the old byte, count stays 1, next read returns the new byte.
- With PS2_VRAM_BRIDGE_IRQ_EN defined: one push -> irq=1; one DATA read -> irq=0 on the following cycle. Assert rst while the FIFO is non-empty -> after the edge, count=0 and irq=0.
